// File: rtl/wb_stage.sv
// Write-back stage: MEM -> regfile write port with one-entry skid buffer,
// big-endian load alignment/extension, and stall/flush handling.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_wreg,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ld_op,
    input  logic [DATA_W-1:0] mem_ld_data,
    input  logic [1:0]        mem_addr_lo,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LW  = 3'd5;

    typedef struct packed {
        logic              wreg;
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            out_q;
    entry_t            skid_q;
    entry_t            in_c;
    logic              out_valid;
    logic              skid_valid;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_fmt;
    logic              accept;
    logic              drain;

    // Pick the addressed byte/halfword (big-endian) and extend into the incoming entry
    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        ld_fmt  = mem_wdata;
        case (mem_addr_lo)
            2'd0:    ld_byte = mem_ld_data[DATA_W-1 -: 8];
            2'd1:    ld_byte = mem_ld_data[DATA_W-9 -: 8];
            2'd2:    ld_byte = mem_ld_data[15:8];
            default: ld_byte = mem_ld_data[7:0];
        endcase
        ld_half = mem_addr_lo[1] ? mem_ld_data[15:0] : mem_ld_data[DATA_W-1 -: 16];
        case (mem_ld_op)
            LD_LB:   ld_fmt = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_fmt = {{(DATA_W-8){1'b0}}, ld_byte};
            LD_LH:   ld_fmt = {{(DATA_W-16){ld_half[15]}}, ld_half};
            LD_LHU:  ld_fmt = {{(DATA_W-16){1'b0}}, ld_half};
            LD_LW:   ld_fmt = mem_ld_data;
            default: ld_fmt = mem_wdata;
        endcase
        in_c.wreg = mem_wreg;
        in_c.wd   = mem_wd;
        in_c.data = ld_fmt;
    end

    // Skid occupancy is the only thing that blocks MEM, so ready is a pure register
    assign mem_ready = ~skid_valid;
    assign accept    = mem_valid & mem_ready & ~flush;
    assign drain     = out_valid & ~stall;

    // Output and skid registers; skid always refills out first to keep program order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                out_q      <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || drain) begin
                out_q     <= in_c;
                out_valid <= 1'b1;
            end else begin
                skid_q     <= in_c;
                skid_valid <= 1'b1;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Regfile port driven straight from the output register; r0 and non-writers never write
    always_comb begin
        wb_we    = out_valid & out_q.wreg & (out_q.wd != '0) & ~stall & ~flush;
        wb_waddr = out_valid ? out_q.wd : '0;
        wb_wdata = out_valid ? out_q.data : '0;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: scoreboard of expected regfile writes plus directed corner sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wreg;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ld_op;
    logic [31:0] mem_ld_data;
    logic [1:0]  mem_addr_lo;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wreg(mem_wreg),
        .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_ld_op(mem_ld_op),
        .mem_ld_data(mem_ld_data), .mem_addr_lo(mem_addr_lo),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic [31:0] ld;
        logic [1:0]  lo;
        logic [31:0] exp;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic lat_mode = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every observed write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && wb_we) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=%h expected no write (t=%0t)",
                         wb_waddr, wb_wdata, $time);
            end else begin
                e = sb.pop_front();
                if (wb_waddr !== e.waddr || wb_wdata !== e.wdata || (e.lat && cyc != e.acc)) begin
                    n_fail++;
                    $display("FAIL wb_write: got r%0d=%h cyc %0d expected r%0d=%h cyc %0d",
                             wb_waddr, wb_wdata, cyc, e.waddr, e.wdata, e.acc);
                end
            end
        end
    end

    task automatic drive(input logic v, input vec_t t);
        mem_valid   = v;
        mem_wreg    = t.wreg;
        mem_wd      = t.wd;
        mem_wdata   = t.wdata;
        mem_ld_op   = t.op;
        mem_ld_data = t.ld;
        mem_addr_lo = t.lo;
    endtask

    task automatic expect_write(input vec_t t);
        exp_t e;
        if (t.wreg && t.wd != 5'd0) begin
            e.waddr = t.wd;
            e.wdata = t.exp;
            e.lat   = lat_mode;
            e.acc   = cyc;
            sb.push_back(e);
        end
    endtask

    // Present an op, wait (bounded) for ready, return just after the accepting edge
    task automatic send(input vec_t t);
        bit ok = 0;
        drive(1'b1, t);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (ok) expect_write(t);
        else check("send_timeout", 32'd0, 32'd1);
    endtask

    function automatic vec_t alu(input logic [4:0] wd, input logic [31:0] d);
        vec_t t;
        t = '{1'b1, wd, d, 3'd0, 32'h0, 2'd0, d};
        return t;
    endfunction

    task automatic idle_cycles(input int n);
        vec_t z;
        z = alu(5'd0, 32'd0);
        drive(1'b0, z);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        vec_t z;
        vecs[0]  = '{1'b1, 5'd4,  32'h0,        3'd1, 32'h80FF7F01, 2'd0, 32'hFFFFFF80};
        vecs[1]  = '{1'b1, 5'd5,  32'h0,        3'd2, 32'h80FF7F01, 2'd0, 32'h00000080};
        vecs[2]  = '{1'b1, 5'd6,  32'h0,        3'd1, 32'h80FF7F01, 2'd2, 32'h0000007F};
        vecs[3]  = '{1'b1, 5'd7,  32'h0,        3'd1, 32'h80FF7F01, 2'd1, 32'hFFFFFFFF};
        vecs[4]  = '{1'b1, 5'd8,  32'h0,        3'd2, 32'h80FF7F01, 2'd3, 32'h00000001};
        vecs[5]  = '{1'b1, 5'd9,  32'h0,        3'd3, 32'h80FF7F01, 2'd2, 32'h00007F01};
        vecs[6]  = '{1'b1, 5'd10, 32'h0,        3'd3, 32'h80FF7F01, 2'd1, 32'hFFFF80FF};
        vecs[7]  = '{1'b1, 5'd11, 32'h0,        3'd4, 32'h80FF7F01, 2'd0, 32'h000080FF};
        vecs[8]  = '{1'b1, 5'd12, 32'h0,        3'd4, 32'h80FF7F01, 2'd3, 32'h00007F01};
        vecs[9]  = '{1'b1, 5'd13, 32'h0,        3'd5, 32'h80FF7F01, 2'd1, 32'h80FF7F01};
        vecs[10] = '{1'b1, 5'd14, 32'h12345678, 3'd6, 32'h80FF7F01, 2'd0, 32'h12345678};
        vecs[11] = '{1'b1, 5'd15, 32'hCAFEF00D, 3'd7, 32'h80FF7F01, 2'd3, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 5'd16, 32'h55555555, 3'd0, 32'h0,        2'd0, 32'h55555555};

        // Reset state
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        z = alu(5'd0, 32'd0);
        drive(1'b0, z);
        #2;
        check("rst_ready", 32'(mem_ready), 32'd1);
        check("rst_we",    32'(wb_we),     32'd0);
        check("rst_waddr", 32'(wb_waddr),  32'd0);
        check("rst_wdata", wb_wdata,       32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back ALU ops, each written the cycle after acceptance
        lat_mode = 1'b1;
        send(alu(5'd1, 32'h11));
        send(alu(5'd2, 32'h22));
        send(alu(5'd3, 32'h33));
        idle_cycles(2);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Load formatting table, streamed back-to-back
        for (int i = 0; i < 13; i++) send(vecs[i]);
        idle_cycles(2);
        check("loads_drained", 32'(sb.size()), 32'd0);
        lat_mode = 1'b0;

        // Stall three cycles while four ops stream in
        stall = 1'b1;
        z = alu(5'd17, 32'hA1);
        drive(1'b1, z);
        @(posedge clk); #1;
        expect_write(z);
        z = alu(5'd18, 32'hB2);
        drive(1'b1, z);
        @(negedge clk);
        check("stall_we0", 32'(wb_we), 32'd0);
        check("stall_ready1", 32'(mem_ready), 32'd1);
        @(posedge clk); #1;
        expect_write(z);
        z = alu(5'd19, 32'hC3);
        drive(1'b1, z);
        @(negedge clk);
        check("stall_ready0", 32'(mem_ready), 32'd0);
        check("stall_we1", 32'(wb_we), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_hold_ready", 32'(mem_ready), 32'd0);
        check("stall_we2", 32'(wb_we), 32'd0);
        @(posedge clk); #1;
        stall = 1'b0;
        send(alu(5'd19, 32'hC3));
        send(alu(5'd20, 32'hD4));
        idle_cycles(4);
        check("stall_drained", 32'(sb.size()), 32'd0);

        // Flush with both slots full and a third op on the input
        stall = 1'b1;
        drive(1'b1, alu(5'd21, 32'hE1));
        @(posedge clk); #1;
        drive(1'b1, alu(5'd22, 32'hE2));
        @(posedge clk); #1;
        drive(1'b1, alu(5'd23, 32'hE3));
        stall = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("flush_we", 32'(wb_we), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        z = alu(5'd0, 32'd0);
        drive(1'b0, z);
        @(negedge clk);
        check("flush_ready", 32'(mem_ready), 32'd1);
        check("flush_empty_we", 32'(wb_we), 32'd0);
        @(posedge clk); #1;
        lat_mode = 1'b1;
        send(alu(5'd24, 32'hF00D));
        idle_cycles(2);
        check("flush_next_ok", 32'(sb.size()), 32'd0);

        // Write to r0: no write, slot drains so the next op follows without delay
        z = alu(5'd0, 32'hDEADBEEF);
        send(z);
        drive(1'b1, alu(5'd25, 32'h25));
        @(negedge clk);
        check("r0_we", 32'(wb_we), 32'd0);
        check("r0_waddr", 32'(wb_waddr), 32'd0);
        @(posedge clk); #1;
        expect_write(alu(5'd25, 32'h25));
        idle_cycles(2);
        check("r0_drained", 32'(sb.size()), 32'd0);
        lat_mode = 1'b0;

        // Asynchronous reset mid-stream with both slots full
        stall = 1'b1;
        drive(1'b1, alu(5'd26, 32'h26));
        @(posedge clk); #1;
        drive(1'b1, alu(5'd27, 32'h27));
        @(posedge clk); #1;
        check("pre_rst_ready", 32'(mem_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ready", 32'(mem_ready), 32'd1);
        check("midrst_we",    32'(wb_we),     32'd0);
        check("midrst_wdata", wb_wdata,       32'd0);
        z = alu(5'd0, 32'd0);
        drive(1'b0, z);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(3);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
